// File: rtl/demorgan_pkg.sv
// Shared definitions for the pipelined De Morgan datapath stage.
package demorgan_pkg;

    // Width of the per-transaction function select.
    localparam int LOGIC_OP_W = 3;
    localparam int NUM_OPS    = 1 << LOGIC_OP_W;

    // Bitwise function select; the encoding is visible on the op/y_op ports.
    typedef enum logic [LOGIC_OP_W-1:0] {
        OP_AND   = 3'd0,  // a & b
        OP_OR    = 3'd1,  // a | b
        OP_NAND  = 3'd2,  // ~(a & b), direct form
        OP_NOR   = 3'd3,  // ~(a | b), direct form
        OP_NANDN = 3'd4,  // (~a) & (~b), De Morgan form (faultable)
        OP_NORN  = 3'd5,  // (~a) | (~b), De Morgan form (faultable)
        OP_XOR   = 3'd6,  // a ^ b
        OP_XNOR  = 3'd7   // ~(a ^ b)
    } op_t;

endpackage

// File: rtl/demorgan_vec.sv
// Combinational function bank: all eight bitwise results plus the
// direct-vs-De-Morgan mismatch vectors, with fault injection applied to the
// De Morgan paths only.
module demorgan_vec
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic [WIDTH-1:0]                fault_inj,
    output logic [NUM_OPS-1:0][WIDTH-1:0]   res,
    output logic [WIDTH-1:0]                mis_nand,
    output logic [WIDTH-1:0]                mis_nor
);

    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] nand_direct;
    logic [WIDTH-1:0] nor_direct;
    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] nand_dm;
    logic [WIDTH-1:0] nor_dm;

    // Direct forms invert the AND/OR result; the De Morgan forms are built
    // from independently inverted operands so the checker compares two
    // genuinely separate structures.
    assign and_v       = a & b;
    assign or_v        = a | b;
    assign nand_direct = ~and_v;
    assign nor_direct  = ~or_v;
    assign a_n         = ~a;
    assign b_n         = ~b;
    assign nand_dm     = (a_n | b_n) ^ fault_inj;
    assign nor_dm      = (a_n & b_n) ^ fault_inj;

    // Any bit where the two structures disagree is a checker hit.
    assign mis_nand = nand_direct ^ nand_dm;
    assign mis_nor  = nor_direct  ^ nor_dm;

    // Result table indexed by op encoding.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        res            = '0;
        res[OP_AND]    = and_v;
        res[OP_OR]     = or_v;
        res[OP_NAND]   = nand_direct;
        res[OP_NOR]    = nor_direct;
        res[OP_NANDN]  = nor_dm;
        res[OP_NORN]   = nand_dm;
        res[OP_XOR]    = a ^ b;
        res[OP_XNOR]   = ~(a ^ b);
    end

endmodule

// File: rtl/demorgan_pipe.sv
// Registered valid/ready datapath stage applying one of eight bitwise
// functions per transaction, with a continuous De Morgan equivalence checker
// feeding a sticky error flag and a saturating mismatch counter.
module demorgan_pipe
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [LOGIC_OP_W-1:0] op,
    input  logic [WIDTH-1:0]      fault_inj,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      y,
    output logic [LOGIC_OP_W-1:0] y_op,
    output logic                  err_flag,
    output logic [CNT_W-1:0]      err_count,
    input  logic                  clr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_OPS-1:0][WIDTH-1:0] res;
    logic [WIDTH-1:0]              mis_nand;
    logic [WIDTH-1:0]              mis_nor;
    logic                          xfer_in;
    logic                          mismatch;
    op_t                           op_sel;

    demorgan_vec #(
        .WIDTH (WIDTH)
    ) u_vec (
        .a         (a),
        .b         (b),
        .fault_inj (fault_inj),
        .res       (res),
        .mis_nand  (mis_nand),
        .mis_nor   (mis_nor)
    );

    // The output slot frees up whenever it is empty or being drained this
    // cycle, which allows back-to-back transfers at full throughput.
    assign in_ready = ~out_valid | out_ready;
    assign xfer_in  = in_valid & in_ready;
    assign mismatch = |(mis_nand | mis_nor);
    assign op_sel   = op_t'(op);

    // Output register: load on accept, drop valid once drained, else hold.
    // Operands are only sampled under xfer_in, so idle-cycle X never lands in state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            out_valid <= 1'b0;
            y         <= '0;
            y_op      <= '0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            y         <= res[op_sel];
            y_op      <= op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Checker: clear takes effect first, then an accepted mismatch counts,
    // so a collision leaves the counter at one with the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            if (clr_err) begin
                err_flag  <= 1'b0;
                err_count <= '0;
            end
            if (xfer_in && mismatch) begin
                err_flag <= 1'b1;
                if (clr_err) begin
                    err_count <= CNT_W'(1);
                end else if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_demorgan_pipe.sv
// Self-checking bench for demorgan_pipe: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model. A second instance with a 2-bit counter shares the
// stimulus to exercise counter saturation.
module tb_demorgan_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] fault_inj;
    logic             out_ready;
    logic             clr_err;

    logic             in_ready,  in_ready2;
    logic             out_valid, out_valid2;
    logic [WIDTH-1:0] y,         y2;
    logic [2:0]       y_op,      y_op2;
    logic             err_flag,  err_flag2;
    logic [15:0]      err_count;
    logic [1:0]       err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demorgan_pipe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .fault_inj(fault_inj),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_op(y_op),
        .err_flag(err_flag), .err_count(err_count), .clr_err(clr_err)
    );

    demorgan_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .fault_inj(fault_inj),
        .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .y_op(y_op2),
        .err_flag(err_flag2), .err_count(err_count2), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference function: what each op means, with the fault mask landing on
    // the two De Morgan-form ops only.
    function automatic logic [WIDTH-1:0] ref_fn(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                                input logic [2:0] fop, input logic [WIDTH-1:0] ffi);
        case (fop)
            3'd0:    return fa & fb;
            3'd1:    return fa | fb;
            3'd2:    return ~(fa & fb);
            3'd3:    return ~(fa | fb);
            3'd4:    return ~(fa | fb) ^ ffi;
            3'd5:    return ~(fa & fb) ^ ffi;
            3'd6:    return fa ^ fb;
            default: return ~(fa ^ fb);
        endcase
    endfunction

    // Transaction-level model. The two forms are logically equal, so a
    // mismatch occurs exactly when the fault mask is non-zero.
    logic             m_valid;
    logic [WIDTH-1:0] m_y;
    logic [2:0]       m_op;
    logic             m_flag;
    int               m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_y = '0; m_op = '0; m_flag = 1'b0; m_cnt = 0;
        end else begin
            if (clr_err) begin
                m_cnt = 0; m_flag = 1'b0;
            end
            if (in_valid && (!m_valid || out_ready)) begin
                m_y     = ref_fn(a, b, op, fault_inj);
                m_op    = op;
                m_valid = 1'b1;
                if (fault_inj != '0) begin
                    m_cnt++;
                    m_flag = 1'b1;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready",   32'(in_ready),   32'(!m_valid || out_ready));
            check("out_valid",  32'(out_valid),  32'(m_valid));
            check("y",          32'(y),          32'(m_y));
            check("y_op",       32'(y_op),       32'(m_op));
            check("err_flag",   32'(err_flag),   32'(m_flag));
            check("err_count",  32'(err_count),  32'((m_cnt > 65535) ? 65535 : m_cnt));
            check("out_valid2", 32'(out_valid2), 32'(m_valid));
            check("y2",         32'(y2),         32'(m_y));
            check("err_flag2",  32'(err_flag2),  32'(m_flag));
            check("err_count2", 32'(err_count2), 32'((m_cnt > 3) ? 3 : m_cnt));
        end
    end

    // Present one transaction, wait (bounded) for acceptance, then go idle.
    task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [2:0] top, input logic [WIDTH-1:0] tfi);
        int n = 0;
        in_valid = 1'b1; a = ta; b = tb_v; op = top; fault_inj = tfi;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 'x; b = 'x; op = 'x; fault_inj = '0;
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] lit_y [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h03, 8'h3F, 8'h3C, 8'hC3};
        logic [1:0]       sat_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        fault_inj = '0; out_ready = 1'b1; clr_err = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y",         32'(y),         32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;

        // All eight ops back to back on a=F0, b=CC.
        for (int i = 0; i < 8; i++) begin
            drive(8'hF0, 8'hCC, 3'(i), 8'h00);
            check("lit_op_y",      32'(y),         32'(lit_y[i]));
            check("lit_op_valid",  32'(out_valid), 32'd1);
            check("lit_op_errcnt", 32'(err_count), 32'd0);
        end

        // Backpressure: drain, then hold a NAND result for three cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(8'hAA, 8'h0F, 3'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_y_held",   32'(y),        32'hF5);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        #1;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; op = 3'd0;
        @(negedge clk); #1;
        check("bp_pending_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_same_cycle_y", 32'(y), 32'h10);

        // Fault injection on the De Morgan NAND path.
        clear_errs();
        drive(8'hFF, 8'hFF, 3'd5, 8'h01);
        check("fault_y",     32'(y),         32'h01);
        check("fault_flag",  32'(err_flag),  32'd1);
        check("fault_count", 32'(err_count), 32'd1);

        // Saturation of the 2-bit counter.
        clear_errs();
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom), 8'($urandom), 3'($urandom), 8'h80);
            check("sat_count2", 32'(err_count2), 32'(sat_seq[i]));
        end

        // Clear colliding with a faulted accept.
        clear_errs();
        drive(8'h01, 8'h02, 3'd4, 8'h10);
        drive(8'h03, 8'h04, 3'd1, 8'h20);
        check("coll_pre_count", 32'(err_count), 32'd2);
        clr_err = 1'b1;
        drive(8'h05, 8'h06, 3'd6, 8'h40);
        clr_err = 1'b0;
        check("coll_count", 32'(err_count), 32'd1);
        check("coll_flag",  32'(err_flag),  32'd1);

        // Asynchronous reset while a result is pending.
        drive(8'hF0, 8'hCC, 3'd6, 8'h00);
        check("pre_rst_y", 32'(y), 32'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_y",     32'(y),         32'd0);
        check("async_rst_count", 32'(err_count), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        drive(8'h5A, 8'h0F, 3'd1, 8'h00);
        check("post_rst_y",     32'(y),         32'h5F);
        check("post_rst_valid", 32'(out_valid), 32'd1);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            fault_inj = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            in_valid  = ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            end else begin
                a = 'x; b = 'x; op = 'x;
            end
            @(negedge clk); #1;
        end
        in_valid = 1'b0; clr_err = 1'b0; fault_inj = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demorgan_pipe.md
Name: demorgan_pipe

Overview:
Parametrised, pipelined successor to the single-bit De Morgan gate block. It takes WIDTH-bit operand pairs under a valid/ready handshake and applies one of eight bitwise functions selected per transaction. It also runs a continuous De Morgan equivalence checker, with fault injection and a saturating mismatch counter. It sits as a registered datapath stage between a producer and a consumer that both use valid/ready.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of mismatch counter (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  stage can accept a transaction
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  function select (encoding below)
fault_inj  input  WIDTH  XOR mask on the De Morgan-form paths only; 0 in normal use
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  registered result
y_op  output  3  op that produced y
err_flag  output  1  sticky: any mismatch seen since reset/clear
err_count  output  CNT_W  number of accepted transactions with a mismatch, saturating
clr_err  input  1  synchronous clear of err_flag/err_count

Behaviour:
- Op encoding: 0 AND a&b; 1 OR a|b; 2 NAND ~(a&b); 3 NOR ~(a|b); 4 NANDN (~a)&(~b); 5 NORN (~a)|(~b); 6 XOR; 7 XNOR.
- Direct forms: ~(a&b) and ~(a|b). These are computed from the AND/OR result and then inverted.
- De Morgan forms: (~a)|(~b) and (~a)&(~b). These are built from separately inverted operands and are not shared with the direct forms.
- fault_inj is XORed into both De Morgan forms. Ops 4/5 therefore output the faulted value.
- Accept: xfer_in = in_valid & in_ready.
- in_ready = ~out_valid | out_ready. Same-cycle drain and refill is supported, giving full throughput.
- Latency: 1 cycle. On xfer_in, y, y_op and out_valid=1 are registered at the next edge.
- If out_valid & ~out_ready, then y, y_op and out_valid hold stable and in_ready=0.
- If out_valid & out_ready & ~in_valid, then out_valid falls to 0 and y holds its last value.
- Checker, on each xfer_in regardless of op:
  - mis_nand = ~(a&b) XOR DeMorgan-NAND form; mis_nor = ~(a|b) XOR DeMorgan-NOR form.
  - mismatch = OR-reduce(mis_nand | mis_nor).
  - mismatch increments err_count by 1, saturating at 2^CNT_W-1 with no wrap, and sets err_flag.
- clr_err: err_count <= 0 and err_flag <= 0. If a mismatch is accepted in the same cycle, the result is err_count = 1 and err_flag = 1 (clear first, then count).
- No transaction is accepted while in_valid=0. Checker and output state never change without xfer_in, except via clr_err.
- Reset (async assert, sync-released by the system):
  - out_valid=0, y=0, y_op=0, err_flag=0, err_count=0.
  - in_ready=1 immediately after reset.
  - An in-flight result is discarded.
- X on a/b/op while in_valid=0 must not propagate to any state.

Decomposition:
- Shared package demorgan_pkg holds:
  - op typedef (3-bit enum: OP_AND, OP_OR, OP_NAND, OP_NOR, OP_NANDN, OP_NORN, OP_XOR, OP_XNOR)
  - LOGIC_OP_W=3
- One combinational sub-module, demorgan_vec (WIDTH param). It produces all eight function results, the two mismatch vectors, and applies fault_inj.
- Top level holds the handshake register, the checker counter/flag and the output mux.

Test Plan:
- WIDTH=8, fault_inj=0, out_ready=1: a=0xF0, b=0xCC, ops 0..7 back-to-back → y = C0, FC, 3F, 03, 03, 3F, 3C, C3 on consecutive cycles; out_valid continuous; err_count stays 0.
- Backpressure: send a=0xAA, b=0x0F, op=2 with out_ready=0 for 3 cycles → y=0xF5 held stable and in_ready=0 throughout; raise out_ready with a new transaction pending → that transaction is accepted in the same cycle.
- Fault injection: fault_inj=0x01, a=0xFF, b=0xFF, op=5 → y=0x01 (direct NAND would be 0x00); err_flag=1; err_count=1.
- Saturation: CNT_W=2, fault_inj≠0 for 5 accepted transactions → err_count sequence 1, 2, 3, 3, 3.
- Clear collision: err_count=2, then clr_err=1 in the same cycle as a faulted accept → err_count=1, err_flag=1.
- Reset mid-operation: assert rst_n=0 while out_valid=1, y=0x3C → out_valid, y and err_count are 0 asynchronously; after release in_ready=1 and the first new transaction returns its correct result after 1 cycle.
